// File: rtl/alu_op_issuer.sv
// Issue stage for the clocked ALU: buffers requests in a FIFO, issues them one
// at a time, waits out the ALU latency and presents the flagged result downstream.
module alu_op_issuer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_choice,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_xtra,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [2:0]       out_op,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  logic [WIDTH-1:0] fifo_a_q  [DEPTH];
  logic [WIDTH-1:0] fifo_b_q  [DEPTH];
  logic [2:0]       fifo_op_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  state_e           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_choice_q, alu_choice_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [2:0]       out_op_q, out_op_d;
  logic             out_carry_q, out_carry_d;
  logic             out_zero_q, out_zero_d;

  logic push, pop;

  // in_ready depends only on registered count, so a same-cycle pop never frees a slot
  assign in_ready = !rst && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_choice_d = alu_choice_q;
    out_valid_d  = out_valid_q;
    out_res_d    = out_res_q;
    out_op_d     = out_op_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          alu_a_d      = fifo_a_q[rd_ptr_q];
          alu_b_d      = fifo_b_q[rd_ptr_q];
          alu_choice_d = fifo_op_q[rd_ptr_q];
          cnt_d        = LW'(ALU_LAT);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          out_res_d   = alu_res;
          out_op_d    = alu_choice_q;
          out_carry_d = (alu_choice_q == 3'd0) && alu_xtra;
          out_zero_d  = (alu_res == '0);
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q]  <= in_a;
      fifo_b_q[wr_ptr_q]  <= in_b;
      fifo_op_q[wr_ptr_q] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_choice_q <= '0;
      out_valid_q  <= 1'b0;
      out_res_q    <= '0;
      out_op_q     <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q      <= count_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_choice_q <= alu_choice_d;
      out_valid_q  <= out_valid_d;
      out_res_q    <= out_res_d;
      out_op_q     <= out_op_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_choice = alu_choice_q;
  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;
  assign out_op     = out_op_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer with a one-cycle registered ALU stand-in.
module tb_alu_op_issuer;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_choice;
  logic         alu_xtra;
  logic         out_valid, out_ready;
  logic [W-1:0] out_res;
  logic [2:0]   out_op;
  logic         out_carry, out_zero, busy;

  alu_op_issuer #(.WIDTH(W), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_choice(alu_choice),
    .alu_res(alu_res), .alu_xtra(alu_xtra),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_op(out_op),
    .out_carry(out_carry), .out_zero(out_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in; xtra is deliberately non-zero for several non-add ops
  always @(posedge clk) begin
    case (alu_choice)
      3'd0: {alu_xtra, alu_res} <= {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: begin alu_res <= alu_a - alu_b; alu_xtra <= (alu_a < alu_b); end
      3'd2: begin alu_res <= alu_a;         alu_xtra <= 1'b0;            end
      3'd3: begin alu_res <= alu_a << 1;    alu_xtra <= alu_a[W-1];      end
      3'd4: begin alu_res <= alu_a >> 1;    alu_xtra <= alu_a[0];        end
      3'd5: begin alu_res <= alu_a & alu_b; alu_xtra <= 1'b1;            end
      3'd6: begin alu_res <= ~alu_a;        alu_xtra <= 1'b1;            end
      default: begin alu_res <= alu_a | alu_b; alu_xtra <= 1'b1;         end
    endcase
  end

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   op;
    logic         carry;
    logic         zero;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errs   = 0;

  function automatic exp_t model(input int a, input int b, input int op);
    int   r;
    exp_t e;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a;
      3: r = a * 2;
      4: r = a / 2;
      5: r = a & b;
      6: r = MASK - a;
      default: r = a | b;
    endcase
    e.res   = W'(r & MASK);
    e.op    = 3'(op);
    e.carry = (op == 0) && (r > MASK);
    e.zero  = ((r & MASK) == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: records accepted requests, retires results, checks HOLD stability
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_res;
  logic [2:0]   hold_op;
  logic         hold_c, hold_z;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      hold_v = 1'b0;
    end else begin
      if (in_valid && in_ready) sbq.push_back(model(in_a, in_b, in_op));
      if (hold_v) begin
        chk("held_res", out_res, hold_res);
        chk("held_op", out_op, hold_op);
        chk("held_carry", out_carry, hold_c);
        chk("held_zero", out_zero, hold_z);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_res", out_res, e.res);
          chk("out_op", out_op, e.op);
          chk("out_carry", out_carry, e.carry);
          chk("out_zero", out_zero, e.zero);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_res;
      hold_op  = out_op;
      hold_c   = out_carry;
      hold_z   = out_zero;
    end
  end

  // Leaves in_valid high on return (at posedge+1) so callers can chain requests
  task automatic send(input int a, input int b, input int op, output int refused);
    refused  = 0;
    in_a     = W'(a);
    in_b     = W'(b);
    in_op    = 3'(op);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      refused++;
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !out_valid && sbq.size() == 0) begin ok = 1; break; end
    end
    chk("drain", ok, 1);
    @(posedge clk);
    #1;
  endtask

  int  rf, n;
  logic done = 1'b0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_choice", alu_choice, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // single add with carry, latency from accept to out_valid
    send(255, 20, 0, rf);
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency_edges", n - 1, 3);
    wait_idle();

    // back-to-back requests
    send(5, 7, 1, rf);
    send(3, 0, 2, rf);
    send(255, 0, 3, rf);
    send(123, 0, 4, rf);
    in_valid = 1'b0;
    wait_idle();

    // fill while consumer stalls
    out_ready = 1'b0;
    send(23, 12, 5, rf);
    send(1, 2, 0, rf);
    send(9, 4, 1, rf);
    send(200, 100, 0, rf);
    send(77, 0, 6, rf);
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_full", in_ready, 0);
    chk("stalled_res", out_res, 4);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    // request waiting on full FIFO while the first pop becomes possible
    out_ready = 1'b1;
    send(60, 70, 7, rf);
    in_valid = 1'b0;
    chk("refused_while_full", rf, 2);
    wait_idle();
    chk("in_ready_after_drain", in_ready, 1);

    // not / or / zero results
    send(43, 0, 6, rf);
    send(42, 22, 7, rf);
    send(0, 0, 5, rf);
    send(17, 17, 1, rf);
    in_valid = 1'b0;
    wait_idle();

    // randomized traffic with random backpressure
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 7), rf);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();

    // reset while an op is in WAIT with two more queued
    send(1, 2, 0, rf);
    send(3, 4, 0, rf);
    send(5, 6, 0, rf);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_choice", alu_choice, 0);
    chk("midrst_in_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("stale_results", n, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
